// File: rtl/ellipse_raster_if.sv
// ellipse_raster_if: draw request, status and pixel-descriptor handshake of ellipse_raster
interface ellipse_raster_if #(parameter int COORD_W = 10);
  logic start, fill, busy, done, pix_valid, pix_ready;
  logic [COORD_W-1:0] x0_in, y0_in, a_in, b_in, pix_x, pix_x_end, pix_y;
  modport master(
    output start, fill, x0_in, y0_in, a_in, b_in, pix_ready,
    input busy, done, pix_valid, pix_x, pix_x_end, pix_y
  );
  modport slave(
    input start, fill, x0_in, y0_in, a_in, b_in, pix_ready,
    output busy, done, pix_valid, pix_x, pix_x_end, pix_y
  );
endinterface

// File: rtl/ellipse_raster.sv
// ellipse_raster: midpoint ellipse rasteriser emitting clipped outline pixels or filled spans
module ellipse_raster #(
  parameter int COORD_W = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic clk,
  input logic rst_,
  ellipse_raster_if.slave io
);
  localparam int CW = COORD_W + 2;
  localparam int W = 4 * COORD_W + 4;
  localparam logic signed [CW-1:0] XMAX = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] YMAX = CW'(SCREEN_H - 1);
  typedef enum logic [2:0] {IDLE, INIT, REGION1, REGION2, EMIT, DONE} state_t;
  state_t state, state_nx, ret;
  logic fill_r, deg, pv, emit_end;
  logic [COORD_W-1:0] x0, y0, a, b;
  logic signed [CW-1:0] x, y, px, mx, py, my;
  logic signed [W-1:0] d, dx, dy, a2, b2, aw, bw, dxn, dyn;
  logic signed [CW-1:0] cs [4], ce [4], cy [4];
  logic [3:0] ok, pend, cand;
  logic [1:0] sel;
  assign aw = W'(a);
  assign bw = W'(b);
  assign deg = ~|a || ~|b;
  assign px = CW'(x0) + x;
  assign mx = CW'(x0) - x;
  assign py = CW'(y0) + y;
  assign my = CW'(y0) - y;
  assign dxn = dx + (b2 <<< 1);
  assign dyn = dy - (a2 <<< 1);
  // Candidates 0..3: outline (+x,+y) (-x,+y) (+x,-y) (-x,-y); fill uses 0 = row +y, 1 = row -y
  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cy[i] = (fill_r ? i[0] : i[1]) ? my : py;
      cs[i] = fill_r ? (mx[CW-1] ? '0 : mx) : (i[0] ? mx : px);
      ce[i] = fill_r ? (px > XMAX ? XMAX : px) : cs[i];
      ok[i] = !cy[i][CW-1] && cy[i] <= YMAX && (fill_r
        ? (!i[1] && (!i[0] || |y) && mx <= XMAX)
        : (!cs[i][CW-1] && cs[i] <= XMAX && (!i[0] || |x) && (!i[1] || |y)));
    end
    cand = pend & ok;
    for (int i = 3; i >= 0; i--) if (cand[i]) sel = 2'(i);
  end
  assign pv = state == EMIT && |cand;
  assign emit_end = state == EMIT && (cand == 4'd0 || (io.pix_ready && (cand & (cand - 4'd1)) == 4'd0));
  assign io.pix_valid = pv;
  assign io.pix_x = pv ? COORD_W'(cs[sel]) : '0;
  assign io.pix_x_end = pv ? COORD_W'(ce[sel]) : '0;
  assign io.pix_y = pv ? COORD_W'(cy[sel]) : '0;
  assign io.busy = state != IDLE && state != DONE;
  assign io.done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = io.start ? INIT : IDLE;
      INIT: state_nx = deg ? EMIT : REGION1;
      REGION1: state_nx = dx < dy ? EMIT : REGION2;
      REGION2: state_nx = y[CW-1] ? DONE : EMIT;
      EMIT: state_nx = emit_end ? ret : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst_ ? IDLE : state_nx;
  // Decision terms are kept scaled by 4 so the half-pixel midpoints stay integral
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (io.start) begin
        fill_r <= io.fill;
        x0 <= io.x0_in;
        y0 <= io.y0_in;
        a <= io.a_in;
        b <= io.b_in;
      end
      INIT: begin
        a2 <= aw * aw;
        b2 <= bw * bw;
        x <= '0;
        y <= deg ? '0 : CW'(b);
        dx <= '0;
        dy <= (aw * aw * bw) <<< 1;
        d <= ((bw * bw) <<< 2) - ((aw * aw * bw) <<< 2) + aw * aw;
        ret <= deg ? DONE : REGION1;
        pend <= '1;
      end
      REGION1: if (dx < dy) begin
        ret <= REGION1;
        pend <= '1;
      end else d <= d + (a2 <<< 1) + a2 - (b2 <<< 1) - b2 - ((dx + dy) <<< 1);
      REGION2: begin
        ret <= REGION2;
        pend <= '1;
      end
      EMIT: begin
        if (pv && io.pix_ready) pend[sel] <= 1'b0;
        if (emit_end && ret == REGION1) begin
          x <= x + CW'(1);
          dx <= dxn;
          if (d[W-1]) d <= d + ((dxn + b2) <<< 2);
          else begin
            y <= y - CW'(1);
            dy <= dyn;
            d <= d + ((dxn - dyn + b2) <<< 2);
          end
        end else if (emit_end && ret == REGION2) begin
          y <= y - CW'(1);
          dy <= dyn;
          if (!d[W-1] && |d) d <= d + ((a2 - dyn) <<< 2);
          else begin
            x <= x + CW'(1);
            dx <= dxn;
            d <= d + ((dxn - dyn + a2) <<< 2);
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ellipse_raster.sv
// tb_ellipse_raster: scenario tasks checking ellipse_raster against an equation-level ellipse model
module tb_ellipse_raster;
  localparam int scr_w = 640;
  localparam int scr_h = 480;
  typedef struct packed {int x; int xe; int y;} desc_t;
  logic clk = 0, rst_ = 1;
  int checks = 0, failures = 0;
  desc_t got_q[$], exp_q[$], circ_q[$];
  ellipse_raster_if #(.COORD_W(10)) io();
  ellipse_raster #(.COORD_W(10), .SCREEN_W(scr_w), .SCREEN_H(scr_h)) dut(.clk(clk), .rst_(rst_), .io(io));
  always #5 clk = ~clk;

  function automatic desc_t mk(int x, int xe, int y);
    desc_t r;
    r.x = x;
    r.xe = xe;
    r.y = y;
    return r;
  endfunction

  function automatic void put(int x0, int y0, int x, int y, bit f);
    if (f) begin
      for (int k = 0; k < (y != 0 ? 2 : 1); k++) begin
        int r = k ? y0 - y : y0 + y;
        int lo = x0 - x;
        int hi = x0 + x;
        if (r >= 0 && r < scr_h && hi >= 0 && lo < scr_w)
          exp_q.push_back(mk(lo < 0 ? 0 : lo, hi > scr_w - 1 ? scr_w - 1 : hi, r));
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int sx = (k % 2 != 0) ? x0 - x : x0 + x;
        int sy = (k / 2 != 0) ? y0 - y : y0 + y;
        if (!((k % 2 != 0 && x == 0) || (k / 2 != 0 && y == 0)) && sx >= 0 && sx < scr_w && sy >= 0 && sy < scr_h)
          exp_q.push_back(mk(sx, sx, sy));
      end
    end
  endfunction

  // Decisions evaluated directly from the ellipse equation at each midpoint
  function automatic void model(int x0, int y0, int a, int b, bit f);
    longint a2 = longint'(a) * a;
    longint b2 = longint'(b) * b;
    longint d;
    int x = 0;
    int y = b;
    exp_q.delete();
    if (a == 0 || b == 0) begin
      put(x0, y0, 0, 0, f);
      return;
    end
    while (b2 * x < a2 * y) begin
      put(x0, y0, x, y, f);
      d = 4 * b2 * (x + 1) * (x + 1) + a2 * (2 * y - 1) * (2 * y - 1) - 4 * a2 * b2;
      if (d >= 0) y--;
      x++;
    end
    while (y >= 0) begin
      put(x0, y0, x, y, f);
      d = b2 * (2 * x + 1) * (2 * x + 1) + 4 * a2 * (y - 1) * (y - 1) - 4 * a2 * b2;
      if (d <= 0) x++;
      y--;
    end
  endfunction

  function automatic int qdiff();
    int n = 0;
    if (got_q.size() != exp_q.size()) return -1;
    foreach (got_q[i]) if (got_q[i] != exp_q[i]) n++;
    return n;
  endfunction

  task automatic start_draw(input int x0, input int y0, input int a, input int b, input bit f);
    io.start = 1;
    io.fill = f;
    io.x0_in = 10'(x0);
    io.y0_in = 10'(y0);
    io.a_in = 10'(a);
    io.b_in = 10'(b);
    @(negedge clk);
    io.start = 0;
  endtask

  task automatic collect(input int stall_after, input int stall_len, input int max_acc, input bit rnd, output bit saw_done);
    int acc = 0;
    int st = 0;
    int cyc = 0;
    bit held = 0;
    desc_t h = '0;
    desc_t c;
    got_q.delete();
    saw_done = 0;
    forever begin
      c = mk(int'(io.pix_x), int'(io.pix_x_end), int'(io.pix_y));
      if (held) begin
        checks++;
        if (io.pix_valid !== 1'b1 || c != h) begin
          failures++;
          $display("FAIL hold_stable got v=%0b (%0d,%0d,%0d) need v=1 (%0d,%0d,%0d)", io.pix_valid, c.x, c.xe, c.y, h.x, h.xe, h.y);
        end
      end
      io.pix_ready = rnd ? ($urandom_range(0, 3) != 0) : !(io.pix_valid && acc == stall_after && st < stall_len);
      held = io.pix_valid && !io.pix_ready;
      h = c;
      if (held) st++;
      if (io.pix_valid && io.pix_ready) begin
        got_q.push_back(c);
        acc++;
      end
      if (io.done) begin
        saw_done = 1;
        checks++;
        if (io.busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_in_done got %0b need 0", io.busy);
        end
        break;
      end
      if (acc == max_acc) break;
      if (++cyc > 20000) begin
        checks++;
        failures++;
        $display("FAIL collect_timeout got no done after %0d cycles need done", cyc);
        break;
      end
      @(negedge clk);
    end
    io.pix_ready = 1;
  endtask

  task automatic test_reset();
    rst_ = 1;
    io.start = 1;
    io.fill = 0;
    io.pix_ready = 1;
    io.x0_in = 10'd100;
    io.y0_in = 10'd100;
    io.a_in = 10'd10;
    io.b_in = 10'd10;
    repeat (3) @(negedge clk);
    checks++;
    if ({io.busy, io.done, io.pix_valid} !== 3'b000 || {io.pix_x, io.pix_x_end, io.pix_y} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b v=%0b x=%0d xe=%0d y=%0d need all 0", io.busy, io.done, io.pix_valid, io.pix_x, io.pix_x_end, io.pix_y);
    end
    rst_ = 0;
    io.start = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (io.busy !== 1'b0) begin
      failures++;
      $display("FAIL start_in_reset got busy=%0b need 0", io.busy);
    end
  endtask

  task automatic test_circle();
    bit ok;
    int r2;
    int dup = 0;
    int bad = 0;
    desc_t want [3];
    want[0] = mk(110, 110, 100);
    want[1] = mk(90, 90, 100);
    want[2] = mk(100, 100, 90);
    model(100, 100, 10, 10, 0);
    start_draw(100, 100, 10, 10, 0);
    checks++;
    if (io.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got %0b need 1", io.busy);
    end
    collect(-1, 0, -1, 0, ok);
    circ_q = got_q;
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL circle_seq got %0d descs diff=%0d done=%0b need %0d descs", got_q.size(), qdiff(), ok, exp_q.size());
    end
    checks++;
    if (got_q.size() == 0 || got_q[0] != mk(100, 100, 110)) begin
      failures++;
      $display("FAIL circle_first got %0d descs need first (100,110)", got_q.size());
    end
    for (int w = 0; w < 3; w++) begin
      int n = 0;
      foreach (got_q[i]) if (got_q[i] == want[w]) n++;
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL circle_has got %0d copies of (%0d,%0d) need 1", n, want[w].x, want[w].y);
      end
    end
    foreach (got_q[i]) begin
      r2 = (got_q[i].x - 100) ** 2 + (got_q[i].y - 100) ** 2;
      if (r2 < 81 || r2 > 121) bad++;
      for (int j = 0; j < i; j++) if (got_q[j] == got_q[i]) dup++;
    end
    checks++;
    if (bad != 0 || dup != 0) begin
      failures++;
      $display("FAIL circle_shape got off_radius=%0d duplicates=%0d need 0 and 0", bad, dup);
    end
    @(negedge clk);
    checks++;
    if (io.done !== 1'b0 || io.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got done=%0b busy=%0b need 0 0", io.done, io.busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_draw(100, 100, 10, 10, 0);
    collect(7, 5, -1, 0, ok);
    exp_q = circ_q;
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL backpressure_seq got %0d descs diff=%0d need %0d", got_q.size(), qdiff(), exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_clip();
    bit ok;
    int wrap = 0;
    model(2, 2, 10, 10, 0);
    start_draw(2, 2, 10, 10, 0);
    collect(-1, 0, -1, 0, ok);
    foreach (got_q[i]) if (got_q[i].x >= scr_w - 10 || got_q[i].y >= scr_w - 10) wrap++;
    checks++;
    if (!ok || qdiff() != 0 || wrap != 0) begin
      failures++;
      $display("FAIL clip_outline got %0d descs diff=%0d wrapped=%0d done=%0b need %0d descs no wrap", got_q.size(), qdiff(), wrap, ok, exp_q.size());
    end
    @(negedge clk);
    start_draw(1000, 1000, 5, 5, 0);
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || got_q.size() != 0) begin
      failures++;
      $display("FAIL clip_all got %0d descs done=%0b need 0 descs and done", got_q.size(), ok);
    end
    @(negedge clk);
  endtask

  task automatic test_clip_fill();
    bit ok;
    int zero = 0;
    model(2, 2, 10, 10, 1);
    start_draw(2, 2, 10, 10, 1);
    collect(-1, 0, -1, 0, ok);
    foreach (got_q[i]) if (got_q[i].x == 0) zero++;
    checks++;
    if (!ok || qdiff() != 0 || zero == 0) begin
      failures++;
      $display("FAIL clip_fill got %0d spans diff=%0d clamped=%0d need %0d spans some clamped", got_q.size(), qdiff(), zero, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    bit ok;
    int rows = 0;
    int bad = 0;
    model(50, 50, 3, 3, 1);
    start_draw(50, 50, 3, 3, 1);
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL fill_seq got %0d spans diff=%0d need %0d", got_q.size(), qdiff(), exp_q.size());
    end
    for (int r = 47; r <= 53; r++) begin
      int hit = 0;
      foreach (got_q[i]) if (got_q[i].y == r) hit = 1;
      rows += hit;
    end
    checks++;
    if (rows != 7) begin
      failures++;
      $display("FAIL fill_rows got %0d rows covered need 7", rows);
    end
    checks++;
    if (got_q.size() < 2 || got_q[0] != mk(50, 50, 53) || got_q[1] != mk(50, 50, 47)) begin
      failures++;
      $display("FAIL fill_top got %0d spans need (50..50,53) then (50..50,47)", got_q.size());
    end
    rows = 0;
    foreach (got_q[i]) begin
      if (got_q[i] == mk(47, 53, 50)) rows++;
      for (int j = 0; j < i; j++)
        if (got_q[j].y == got_q[i].y && (got_q[i].x > got_q[j].x || got_q[i].xe < got_q[j].xe)) bad++;
    end
    checks++;
    if (rows != 1 || bad != 0) begin
      failures++;
      $display("FAIL fill_rows_nest got row50_full=%0d not_nested=%0d need 1 and 0", rows, bad);
    end
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    bit ok;
    start_draw(5, 7, 0, 0, 0);
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || got_q.size() != 1 || got_q[0] != mk(5, 5, 7)) begin
      failures++;
      $display("FAIL degenerate got %0d descs done=%0b need one (5,5,7)", got_q.size(), ok);
    end
    @(negedge clk);
    model(30, 30, 4, 4, 0);
    start_draw(30, 30, 4, 4, 0);
    io.start = 1;
    io.x0_in = 10'd200;
    io.a_in = 10'd9;
    io.fill = 1;
    io.pix_ready = 0;
    repeat (2) @(negedge clk);
    io.start = 0;
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL start_while_busy got %0d descs diff=%0d need %0d", got_q.size(), qdiff(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge clk);
    checks++;
    if (io.done !== 1'b0 || io.busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done got done=%0b busy=%0b need 0 0", io.done, io.busy);
    end
    model(300, 200, 20, 7, 0);
    start_draw(300, 200, 20, 7, 0);
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL back_to_back got %0d descs diff=%0d need %0d", got_q.size(), qdiff(), exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_draw(100, 100, 10, 10, 0);
    collect(-1, 0, 20, 0, ok);
    rst_ = 1;
    @(negedge clk);
    checks++;
    if (io.busy !== 1'b0 || io.pix_valid !== 1'b0 || {io.pix_x, io.pix_x_end, io.pix_y} !== 30'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%0b v=%0b x=%0d need 0 0 0", io.busy, io.pix_valid, io.pix_x);
    end
    rst_ = 0;
    @(negedge clk);
    model(100, 100, 10, 10, 0);
    start_draw(100, 100, 10, 10, 0);
    collect(-1, 0, -1, 0, ok);
    checks++;
    if (!ok || qdiff() != 0) begin
      failures++;
      $display("FAIL redraw_after_reset got %0d descs diff=%0d need %0d", got_q.size(), qdiff(), exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    for (int n = 0; n < 8; n++) begin
      int x0 = int'($urandom_range(0, 760));
      int y0 = int'($urandom_range(0, 600));
      int a = int'($urandom_range(0, 40));
      int b = int'($urandom_range(0, 40));
      bit f = 1'($urandom_range(0, 1));
      model(x0, y0, a, b, f);
      start_draw(x0, y0, a, b, f);
      collect(-1, 0, -1, 1, ok);
      checks++;
      if (!ok || qdiff() != 0) begin
        failures++;
        $display("FAIL random_draw (%0d,%0d,%0d,%0d,f=%0b) got %0d descs diff=%0d need %0d", x0, y0, a, b, f, got_q.size(), qdiff(), exp_q.size());
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_circle();
    test_backpressure();
    test_clip();
    test_clip_fill();
    test_fill();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
